// File: rtl/alu_seq_if.sv
// Operand/opcode load bus plus start/busy/done handshake for alu_seq.
interface alu_seq_if #(
  parameter int N = 16
);
  logic         load_A;
  logic         load_B;
  logic         load_Op;
  logic         start;
  logic [N-1:0] data_in;
  logic [N-1:0] result;
  logic [4:0]   flags;
  logic         busy;
  logic         done;

  modport master (
    output load_A, load_B, load_Op, start, data_in,
    input  result, flags, busy, done
  );

  modport slave (
    input  load_A, load_B, load_Op, start, data_in,
    output result, flags, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Register-loaded ALU; logic/add/sub finish on the start edge, shifts take amt edges, MUL takes N.
// No backpressure: loads and start are dropped while busy, done is a one-cycle pulse.
module alu_seq #(
  parameter int N         = 16,
  parameter bit ARITH_SHR = 1'b0
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam int CW = SW + 1;

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [2:0] {
    OP_NOR  = 3'd0,
    OP_NAND = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_MUL  = 3'd7
  } op_t;

  state_t         state_q, state_d;
  op_t            op_q, op_d, wop_q, wop_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [N-1:0]   res_q, res_d;
  logic [4:0]     flags_q, flags_d;
  logic           done_q, done_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   sh_q, sh_d, mpl_q, mpl_d;
  logic [2*N-1:0] mcand_q, mcand_d, acc_q, acc_d;

  logic [N:0]     sum, dif;
  logic [SW-1:0]  amt;
  logic [N-1:0]   imm_res;
  logic           imm_c, imm_v, imm_multi;
  logic [N-1:0]   sh_nxt;
  logic           sh_out;
  logic [2*N-1:0] acc_nxt;

  function automatic logic [4:0] mk_flags(input logic [N-1:0] r, input logic c, input logic v);
    return {v, c, ~|r, r[N-1], ~^r};
  endfunction

  // Single-cycle datapath on the committed registers, plus the multi-cycle decision.
  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, b_q};
    dif       = {1'b0, a_q} - {1'b0, b_q};
    amt       = b_q[SW-1:0];
    imm_res   = a_q;
    imm_c     = 1'b0;
    imm_v     = 1'b0;
    imm_multi = 1'b0;
    case (op_q)
      OP_NOR:  imm_res = ~(a_q | b_q);
      OP_NAND: imm_res = ~(a_q & b_q);
      OP_ADD: begin
        imm_res = sum[N-1:0];
        imm_c   = sum[N];
        imm_v   = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);
      end
      OP_SUB: begin
        imm_res = dif[N-1:0];
        imm_c   = dif[N];
        imm_v   = (a_q[N-1] != b_q[N-1]) && (dif[N-1] != a_q[N-1]);
      end
      OP_XOR:         imm_res = a_q ^ b_q;
      OP_SHL, OP_SHR: imm_multi = (amt != '0);
      OP_MUL:         imm_multi = 1'b1;
      default:        imm_res = a_q;
    endcase
  end

  // One iteration of the working shift / shift-add multiply.
  always_comb begin
    if (wop_q == OP_SHL) begin
      sh_nxt = {sh_q[N-2:0], 1'b0};
      sh_out = sh_q[N-1];
    end else begin
      sh_nxt = {ARITH_SHR & sh_q[N-1], sh_q[N-1:1]};
      sh_out = sh_q[0];
    end
    acc_nxt = mpl_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    wop_d   = wop_q;
    res_d   = res_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    mpl_d   = mpl_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (bus.load_A)  a_d  = bus.data_in;
        if (bus.load_B)  b_d  = bus.data_in;
        if (bus.load_Op) op_d = op_t'(bus.data_in[2:0]);
        if (bus.start) begin
          if (imm_multi) begin
            state_d = RUN;
            wop_d   = op_q;
            sh_d    = a_q;
            mcand_d = {{N{1'b0}}, a_q};
            mpl_d   = b_q;
            acc_d   = '0;
            cnt_d   = (op_q == OP_MUL) ? CW'(N) : CW'(amt);
          end else begin
            res_d   = imm_res;
            flags_d = mk_flags(imm_res, imm_c, imm_v);
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        cnt_d   = cnt_q - CW'(1);
        sh_d    = sh_nxt;
        mcand_d = mcand_q << 1;
        mpl_d   = mpl_q >> 1;
        acc_d   = acc_nxt;
        // Last iteration: publish straight from the step logic so the result lands on edge k+L.
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (wop_q == OP_MUL) begin
            res_d   = acc_nxt[N-1:0];
            flags_d = mk_flags(acc_nxt[N-1:0], |acc_nxt[2*N-1:N], 1'b0);
          end else begin
            res_d   = sh_nxt;
            flags_d = mk_flags(sh_nxt, sh_out, 1'b0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NOR;
      wop_q   <= OP_NOR;
      res_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      sh_q    <= '0;
      mpl_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      wop_q   <= wop_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      mpl_q   <= mpl_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.result = res_q;
  assign bus.flags  = flags_q;
  assign bus.busy   = (state_q == RUN);
  assign bus.done   = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: logical-SHR and arithmetic-SHR instances on shared stimulus, checked against a transaction-level model.
module tb_alu_seq;
  logic clk;
  logic reset;
  int   total;
  int   bad;
  bit   chk_en;

  alu_seq_if #(.N(16)) bus0 ();
  alu_seq_if #(.N(16)) bus1 ();

  assign bus1.load_A  = bus0.load_A;
  assign bus1.load_B  = bus0.load_B;
  assign bus1.load_Op = bus0.load_Op;
  assign bus1.start   = bus0.start;
  assign bus1.data_in = bus0.data_in;

  alu_seq #(.N(16), .ARITH_SHR(1'b0)) u_log (.clk(clk), .reset(reset), .bus(bus0));
  alu_seq #(.N(16), .ARITH_SHR(1'b1)) u_ari (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: whole-operation results from plain arithmetic, plus latency in edges.
  function automatic void calc(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                               input bit ar, output logic [15:0] r, output logic [4:0] f,
                               output int lat);
    int sa, sb, amt;
    logic c, v;
    logic [31:0] p;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    amt = int'(b[3:0]);
    c = 1'b0; v = 1'b0; lat = 0; r = 16'd0;
    case (op)
      3'd0: r = ~(a | b);
      3'd1: r = ~(a & b);
      3'd2: begin
        r = a + b;
        c = (int'(a) + int'(b)) > 65535;
        v = (sa + sb > 32767) || (sa + sb < -32768);
      end
      3'd3: begin
        r = a - b;
        c = a < b;
        v = (sa - sb > 32767) || (sa - sb < -32768);
      end
      3'd4: r = a ^ b;
      3'd5: begin
        r = a << amt;
        c = (amt > 0) ? a[16-amt] : 1'b0;
        lat = amt;
      end
      3'd6: begin
        r = ar ? 16'($signed(a) >>> amt) : (a >> amt);
        c = (amt > 0) ? a[amt-1] : 1'b0;
        lat = amt;
      end
      default: begin
        p = {16'd0, a} * {16'd0, b};
        r = p[15:0];
        c = |p[31:16];
        lat = 16;
      end
    endcase
    f = {v, c, r == 16'd0, r[15], ~^r};
  endfunction

  logic [15:0] mA[2], mB[2], m_res[2], p_res[2];
  logic [2:0]  mOp[2];
  logic [4:0]  m_flags[2], p_flags[2];
  logic        m_busy[2], m_done[2];
  int          m_left[2];
  logic [15:0] t_r;
  logic [4:0]  t_f;
  int          t_lat;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        mA[d] = 16'd0; mB[d] = 16'd0; mOp[d] = 3'd0;
        m_res[d] = 16'd0; m_flags[d] = 5'd0;
        m_busy[d] = 1'b0; m_done[d] = 1'b0; m_left[d] = 0;
      end else if (m_busy[d]) begin
        m_done[d] = 1'b0;
        m_left[d] = m_left[d] - 1;
        if (m_left[d] == 0) begin
          m_res[d] = p_res[d]; m_flags[d] = p_flags[d];
          m_busy[d] = 1'b0; m_done[d] = 1'b1;
        end
      end else begin
        m_done[d] = 1'b0;
        if (bus0.start) begin
          calc(mOp[d], mA[d], mB[d], d == 1, t_r, t_f, t_lat);
          if (t_lat == 0) begin
            m_res[d] = t_r; m_flags[d] = t_f; m_done[d] = 1'b1;
          end else begin
            p_res[d] = t_r; p_flags[d] = t_f; m_left[d] = t_lat; m_busy[d] = 1'b1;
          end
        end
        if (bus0.load_A)  mA[d]  = bus0.data_in;
        if (bus0.load_B)  mB[d]  = bus0.data_in;
        if (bus0.load_Op) mOp[d] = bus0.data_in[2:0];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("log.result", {16'd0, bus0.result}, {16'd0, m_res[0]});
      chk("log.flags",  {27'd0, bus0.flags},  {27'd0, m_flags[0]});
      chk("log.busy",   {31'd0, bus0.busy},   {31'd0, m_busy[0]});
      chk("log.done",   {31'd0, bus0.done},   {31'd0, m_done[0]});
      chk("ari.result", {16'd0, bus1.result}, {16'd0, m_res[1]});
      chk("ari.flags",  {27'd0, bus1.flags},  {27'd0, m_flags[1]});
      chk("ari.busy",   {31'd0, bus1.busy},   {31'd0, m_busy[1]});
      chk("ari.done",   {31'd0, bus1.done},   {31'd0, m_done[1]});
    end
  end

  task automatic ld(input logic la, input logic lb, input logic lo, input logic [15:0] d);
    bus0.load_A = la; bus0.load_B = lb; bus0.load_Op = lo; bus0.data_in = d;
    @(negedge clk);
    bus0.load_A = 1'b0; bus0.load_B = 1'b0; bus0.load_Op = 1'b0;
  endtask

  task automatic setup(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    ld(1'b1, 1'b0, 1'b0, a);
    ld(1'b0, 1'b1, 1'b0, b);
    ld(1'b0, 1'b0, 1'b1, {13'd0, op});
  endtask

  task automatic go();
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget, output int n);
    n = 0;
    while (bus0.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus0.done !== 1'b1) begin
      total++; bad++;
      $display("FAIL %s: done not seen within %0d cycles", nm, budget);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, n2;
    total = 0; bad = 0; chk_en = 0;
    reset = 1'b0;
    bus0.start = 1'b1; bus0.load_A = 1'b1; bus0.load_B = 1'b1; bus0.load_Op = 1'b1;
    bus0.data_in = 16'hFFFF;
    @(posedge clk);
    #1 chk_en = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rst.result", {16'd0, bus0.result}, 32'h0);
    chk("rst.flags",  {27'd0, bus0.flags},  32'h0);
    chk("rst.busy",   {31'd0, bus0.busy},   32'h0);
    chk("rst.done",   {31'd0, bus0.done},   32'h0);
    reset = 1'b1;
    bus0.start = 1'b0; bus0.load_A = 1'b0; bus0.load_B = 1'b0; bus0.load_Op = 1'b0;
    bus0.data_in = 16'h0000;
    @(negedge clk);

    // Loads during reset must not stick: NOR of zero registers
    go();
    chk("nor0.result", {16'd0, bus0.result}, 32'hFFFF);
    chk("nor0.flags",  {27'd0, bus0.flags},  32'b00011);

    setup(16'h7FFF, 16'h0001, 3'd2);
    go();
    chk("add.result", {16'd0, bus0.result}, 32'h8000);
    chk("add.flags",  {27'd0, bus0.flags},  32'b10010);
    chk("add.done",   {31'd0, bus0.done},   32'h1);
    @(negedge clk);
    chk("add.done_drop", {31'd0, bus0.done}, 32'h0);

    setup(16'h0001, 16'h0002, 3'd3);
    go();
    chk("sub.result", {16'd0, bus0.result}, 32'hFFFF);
    chk("sub.flags",  {27'd0, bus0.flags},  32'b01011);

    setup(16'hFFFF, 16'hFFFF, 3'd1);
    go();
    chk("nand.result", {16'd0, bus0.result}, 32'h0);
    chk("nand.flags",  {27'd0, bus0.flags},  32'b00101);

    // All three loads in one cycle, then start held two cycles
    ld(1'b1, 1'b1, 1'b1, 16'h0004);
    bus0.start = 1'b1;
    @(negedge clk);
    chk("xor.done1", {31'd0, bus0.done}, 32'h1);
    chk("xor.result", {16'd0, bus0.result}, 32'h0);
    chk("xor.flags",  {27'd0, bus0.flags},  32'b00101);
    @(negedge clk);
    chk("xor.done2", {31'd0, bus0.done}, 32'h1);
    bus0.start = 1'b0;
    @(negedge clk);

    setup(16'h8001, 16'h0004, 3'd5);
    go();
    chk("shl.busy", {31'd0, bus0.busy}, 32'h1);
    wait_done("shl", 40, n);
    chk("shl.lat",    n, 4);
    chk("shl.result", {16'd0, bus0.result}, 32'h0010);
    chk("shl.flags",  {27'd0, bus0.flags},  32'b00000);

    ld(1'b0, 1'b0, 1'b1, 16'h0006);
    go();
    wait_done("shr", 40, n);
    chk("shr.lat",        n, 4);
    chk("shr_ari.result", {16'd0, bus1.result}, 32'hF800);
    chk("shr_ari.flags",  {27'd0, bus1.flags},  32'b00010);
    chk("shr_log.result", {16'd0, bus0.result}, 32'h0800);

    ld(1'b0, 1'b1, 1'b0, 16'h0000);
    go();
    chk("shr0.done",   {31'd0, bus0.done},   32'h1);
    chk("shr0.busy",   {31'd0, bus0.busy},   32'h0);
    chk("shr0.result", {16'd0, bus0.result}, 32'h8001);
    chk("shr0.flags",  {27'd0, bus0.flags},  32'b00011);

    setup(16'h0003, 16'h000F, 3'd5);
    go();
    wait_done("shl15", 40, n);
    chk("shl15.lat",    n, 15);
    chk("shl15.result", {16'd0, bus0.result}, 32'h8000);
    chk("shl15.flags",  {27'd0, bus0.flags},  32'b01010);

    setup(16'h0100, 16'h0100, 3'd7);
    go();
    wait_done("mul", 40, n);
    chk("mul.lat",    n, 16);
    chk("mul.result", {16'd0, bus0.result}, 32'h0);
    chk("mul.flags",  {27'd0, bus0.flags},  32'b01101);

    // load_A and start pulsed while busy must be ignored
    go();
    repeat (3) @(negedge clk);
    bus0.load_A = 1'b1; bus0.start = 1'b1; bus0.data_in = 16'h1234;
    @(negedge clk);
    bus0.load_A = 1'b0; bus0.start = 1'b0;
    wait_done("mul_busy", 40, n2);
    chk("mul_busy.lat",    4 + n2, 16);
    chk("mul_busy.result", {16'd0, bus0.result}, 32'h0);
    @(negedge clk);
    ld(1'b0, 1'b1, 1'b1, 16'h0002);
    go();
    chk("keepA.result", {16'd0, bus0.result}, 32'h0102);
    chk("keepA.flags",  {27'd0, bus0.flags},  32'b00001);

    setup(16'h0003, 16'h0005, 3'd7);
    go();
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort.result", {16'd0, bus0.result}, 32'h0);
    chk("abort.flags",  {27'd0, bus0.flags},  32'h0);
    chk("abort.busy",   {31'd0, bus0.busy},   32'h0);
    chk("abort.done",   {31'd0, bus0.done},   32'h0);
    repeat (20) @(negedge clk);

    setup(16'h0003, 16'h0004, 3'd2);
    go();
    chk("post.result", {16'd0, bus0.result}, 32'h0007);
    chk("post.flags",  {27'd0, bus0.flags},  32'b00000);
    chk("post.done",   {31'd0, bus0.done},   32'h1);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
